// File: rtl/param_counter_if.sv
// rtl/param_counter_if.sv - control and status bundle for param_counter
interface param_counter_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en, up_dn, clr, load, load_val, max_val, div,
        input  count, tc
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, max_val, div,
        output count, tc
    );
endinterface

// File: rtl/param_counter.sv
// rtl/param_counter.sv - modulo up/down counter with prescaler, wrap/saturate and terminal-count pulse
module param_counter #(
    parameter int WIDTH    = 8,
    parameter int DIV_W    = 4,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    param_counter_if.slave bus
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_clamped;
    logic [DIV_W-1:0] pre_cnt;
    logic             step;
    logic             limit;
    logic             hit_q;
    logic             tc_q;

    // >= rather than == so a div lowered below the current phase steps at once
    assign step         = bus.en && (pre_cnt >= bus.div);
    assign load_clamped = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;

    always_comb begin
        next_count = count_q;
        limit      = 1'b0;
        if (count_q > bus.max_val) begin
            limit      = 1'b1;
            next_count = (SATURATE != 0) ? bus.max_val : '0;
        end else if (bus.up_dn) begin
            if (count_q == bus.max_val) begin
                limit      = 1'b1;
                next_count = (SATURATE != 0) ? count_q : '0;
            end else begin
                next_count = count_q + WIDTH'(1);
            end
        end else begin
            if (count_q == '0) begin
                limit      = 1'b1;
                next_count = (SATURATE != 0) ? count_q : bus.max_val;
            end else begin
                next_count = count_q - WIDTH'(1);
            end
        end
    end

    // hit_q marks a limit step; tc re-registers it so the pulse trails the count change by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            pre_cnt <= '0;
            hit_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else if (bus.clr) begin
            count_q <= '0;
            pre_cnt <= '0;
            hit_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            pre_cnt <= '0;
            hit_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            tc_q  <= hit_q;
            if (bus.en) begin
                if (step) begin
                    count_q <= next_count;
                    pre_cnt <= '0;
                    hit_q   <= limit;
                end else begin
                    pre_cnt <= pre_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - scoreboard bench driving wrap and saturate counters with shared directed vectors
module tb_param_counter;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    param_counter_if #(.WIDTH(4), .DIV_W(4)) wif ();
    param_counter_if #(.WIDTH(4), .DIV_W(4)) sif ();

    param_counter #(.WIDTH(4), .DIV_W(4), .SATURATE(0)) u_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (wif.slave)
    );

    param_counter #(.WIDTH(4), .DIV_W(4), .SATURATE(1)) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    typedef struct {
        string      name;
        bit         cw;
        logic [3:0] wc;
        logic       wt;
        bit         cs;
        logic [3:0] sc;
        logic       st;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int t2_wc[5] = '{1, 0, 9, 8, 7};
    int t2_wt[5] = '{0, 0, 0, 1, 0};
    int t2_sc[5] = '{8, 7, 6, 5, 4};
    int t2_st[5] = '{1, 0, 0, 0, 0};
    int t3_wc[8] = '{1, 0, 5, 4, 3, 2, 1, 0};
    int t3_wt[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int t3_sc[8] = '{4, 3, 2, 1, 0, 0, 0, 0};
    int t3_st[8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    int t4_en[13] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int t4_c[13]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3};

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic drive(bit en, bit up, bit clr, bit ld, int lv, int mx, int dv);
        wif.en = en;  wif.up_dn = up;  wif.clr = clr;  wif.load = ld;
        wif.load_val = 4'(lv);  wif.max_val = 4'(mx);  wif.div = 4'(dv);
        sif.en = en;  sif.up_dn = up;  sif.clr = clr;  sif.load = ld;
        sif.load_val = 4'(lv);  sif.max_val = 4'(mx);  sif.div = 4'(dv);
    endtask

    task automatic cyc(string n, bit cw, int wc, int wt, bit cs, int sc, int st);
        exp_t e;
        e.name = n;
        e.cw = cw;  e.wc = 4'(wc);  e.wt = wt[0];
        e.cs = cs;  e.sc = 4'(sc);  e.st = st[0];
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse_reset(string n);
        reset_n = 1'b0;
        #1;
        chk({n, "_wcnt"}, wif.count, 0);
        chk({n, "_wtc"},  wif.tc,    0);
        chk({n, "_scnt"}, sif.count, 0);
        chk({n, "_stc"},  sif.tc,    0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one expectation per clock edge, sampled well clear of the edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cw) begin
                chk({e.name, "_wcnt"}, wif.count, e.wc);
                chk({e.name, "_wtc"},  wif.tc,    e.wt);
            end
            if (e.cs) begin
                chk({e.name, "_scnt"}, sif.count, e.sc);
                chk({e.name, "_stc"},  sif.tc,    e.st);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        drive(0, 1, 0, 0, 0, 9, 0);
        repeat (2) @(negedge clk);
        chk("reset_wcnt", wif.count, 0);
        chk("reset_wtc",  wif.tc,    0);
        chk("reset_scnt", sif.count, 0);
        chk("reset_stc",  sif.tc,    0);
        reset_n = 1'b1;

        // up count to 9, wrap vs saturate
        drive(1, 1, 0, 0, 0, 9, 0);
        for (int i = 1; i <= 12; i++)
            cyc("t1_up", 1, i % 10, (i == 11) ? 1 : 0, 1, (i < 9) ? i : 9, (i >= 11) ? 1 : 0);

        // reverse direction through zero
        drive(1, 0, 0, 0, 0, 9, 0);
        for (int i = 0; i < 5; i++)
            cyc("t2_down", 1, t2_wc[i], t2_wt[i], 1, t2_sc[i], t2_st[i]);

        // saturate at max_val=5 then at zero
        pulse_reset("t3_rst");
        drive(1, 1, 0, 0, 0, 5, 0);
        for (int i = 1; i <= 8; i++)
            cyc("t3_up", 1, i % 6, (i == 7) ? 1 : 0, 1, (i < 5) ? i : 5, (i >= 7) ? 1 : 0);
        drive(1, 0, 0, 0, 0, 5, 0);
        for (int i = 0; i < 8; i++)
            cyc("t3_down", 1, t3_wc[i], t3_wt[i], 1, t3_sc[i], t3_st[i]);

        // prescaler div=2 with en gap
        pulse_reset("t4_rst");
        for (int i = 0; i < 13; i++) begin
            drive(t4_en[i][0], 1, 0, 0, 0, 9, 2);
            cyc("t4_presc", 1, t4_c[i], 0, 1, t4_c[i], 0);
        end

        // load clamp, clr priority, runtime max_val drop, max_val=0
        drive(1, 1, 0, 1, 12, 9, 0);  cyc("t5_clamp",   1, 9, 0, 1, 9, 0);
        drive(0, 1, 0, 0, 0, 9, 0);   cyc("t5_hold",    1, 9, 0, 1, 9, 0);
        drive(0, 1, 1, 1, 5, 9, 0);   cyc("t5_clr_ld",  1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 1, 7, 9, 0);   cyc("t5_load7",   1, 7, 0, 1, 7, 0);
        drive(1, 1, 0, 0, 0, 3, 0);   cyc("t5_force",   1, 0, 0, 1, 3, 0);
        drive(0, 1, 0, 0, 0, 3, 0);   cyc("t5_force_tc", 1, 0, 1, 1, 3, 1);
                                      cyc("t5_tc_end",  1, 0, 0, 1, 3, 0);
        drive(1, 1, 0, 0, 0, 0, 0);   cyc("t5_max0_a",  1, 0, 0, 1, 0, 0);
                                      cyc("t5_max0_b",  1, 0, 1, 1, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0);   cyc("t5_max0_c",  1, 0, 1, 1, 0, 1);
                                      cyc("t5_max0_d",  1, 0, 0, 1, 0, 0);

        // async reset mid prescaler window
        drive(0, 1, 1, 0, 0, 9, 1);   cyc("t6_clr", 1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 9, 1);
        cyc("t6_pre_a", 1, 0, 0, 1, 0, 0);
        cyc("t6_pre_b", 1, 1, 0, 1, 1, 0);
        cyc("t6_pre_c", 1, 1, 0, 1, 1, 0);
        pulse_reset("t6_rst");
        cyc("t6_post_a", 1, 0, 0, 1, 0, 0);
        cyc("t6_post_b", 1, 1, 0, 1, 1, 0);
        cyc("t6_post_c", 1, 1, 0, 1, 1, 0);
        cyc("t6_post_d", 1, 2, 0, 1, 2, 0);

        drive(0, 1, 0, 0, 0, 9, 0);
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
